// File: rtl/hdb3_enc_scheduler.sv
// hdb3_enc_scheduler: time-division arbiter feeding one shared HDB3 encoder chain.
// Define HDB3_SCHED_PRIO_EN for fixed lowest-index priority instead of round robin.
module hdb3_enc_scheduler #(
  parameter int NUM_CH    = 2,
  parameter int BURST_LEN = 16,
  parameter int FLUSH_CYC = 5,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] ch_bit,
  output logic [NUM_CH-1:0] ch_ack,
  output logic [NUM_CH-1:0] grant,
  output logic              enc_en,
  output logic              enc_bit,
  output logic              busy,
  output logic              burst_done
);

  localparam int PW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int FL = (FLUSH_CYC < 1) ? 1 : FLUSH_CYC;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] FL_LAST  = CNT_W'(FL - 1);
  localparam logic [PW-1:0]    CH_LAST  = PW'(NUM_CH - 1);
  localparam logic [PW:0]      CH_NUM   = (PW + 1)'(NUM_CH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    g_idx;

  logic              found;
  logic [PW-1:0]     sel_idx;
  logic [PW:0]       idx_w;
  logic [NUM_CH-1:0] sel_oh;
  logic              cur_req;
  logic              cur_bit;

  // Scan starts at ptr; in the priority build ptr never moves off 0.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    idx_w   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_w = {1'b0, ptr} + (PW + 1)'(i);
      if (idx_w >= CH_NUM) begin
        idx_w = idx_w - CH_NUM;
      end
      if (!found && req[idx_w[PW-1:0]]) begin
        found   = 1'b1;
        sel_idx = idx_w[PW-1:0];
      end
    end
  end

  always_comb begin
    sel_oh = '0;
    sel_oh[sel_idx] = 1'b1;
  end

  assign cur_req = req[g_idx];
  assign cur_bit = ch_bit[g_idx];

  assign ch_ack = (rst && state == S_SEND) ? (grant & req) : '0;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      grant      <= '0;
      g_idx      <= '0;
      ptr        <= '0;
      bit_cnt    <= '0;
      flush_cnt  <= '0;
      enc_en     <= 1'b0;
      enc_bit    <= 1'b0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          enc_en  <= 1'b0;
          enc_bit <= 1'b0;
          if (found) begin
            grant   <= sel_oh;
            g_idx   <= sel_idx;
            busy    <= 1'b1;
            bit_cnt <= '0;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (cur_req) begin
            enc_en  <= 1'b1;
            enc_bit <= cur_bit;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              flush_cnt <= '0;
              state     <= S_FLUSH;
            end
          end else begin
            enc_en    <= 1'b0;
            enc_bit   <= 1'b0;
            flush_cnt <= '0;
            state     <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          enc_en  <= 1'b0;
          enc_bit <= 1'b0;
          if (flush_cnt == FL_LAST) begin
            burst_done <= 1'b1;
            grant      <= '0;
            busy       <= 1'b0;
            flush_cnt  <= '0;
            state      <= S_IDLE;
`ifndef HDB3_SCHED_PRIO_EN
            ptr <= (g_idx == CH_LAST) ? '0 : g_idx + PW'(1);
`endif
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          grant   <= '0;
          busy    <= 1'b0;
          enc_en  <= 1'b0;
          enc_bit <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdb3_enc_scheduler.sv
// tb_hdb3_enc_scheduler: directed checks of grant, burst framing, flush and reset.
// Three instances: (BURST 4, FLUSH 5), (BURST 16, FLUSH 5), (BURST 4, FLUSH 0).
module tb_hdb3_enc_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic clr = 1'b1;

  logic [1:0] req_a, bit_a, ack_a, gnt_a;
  logic [1:0] req_b, bit_b, ack_b, gnt_b;
  logic [1:0] req_c, bit_c, ack_c, gnt_c;
  logic       en_a, eb_a, busy_a, bd_a;
  logic       en_b, eb_b, busy_b, bd_b;
  logic       en_c, eb_c, busy_c, bd_c;

  logic [15:0] pat  [3][2];
  int          ackc [3][2];
  logic [5:0]  lg   [3][512];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          m;

  hdb3_enc_scheduler #(.NUM_CH(2), .BURST_LEN(4), .FLUSH_CYC(5), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .ch_bit(bit_a), .ch_ack(ack_a),
    .grant(gnt_a), .enc_en(en_a), .enc_bit(eb_a), .busy(busy_a), .burst_done(bd_a));

  hdb3_enc_scheduler #(.NUM_CH(2), .BURST_LEN(16), .FLUSH_CYC(5), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .ch_bit(bit_b), .ch_ack(ack_b),
    .grant(gnt_b), .enc_en(en_b), .enc_bit(eb_b), .busy(busy_b), .burst_done(bd_b));

  hdb3_enc_scheduler #(.NUM_CH(2), .BURST_LEN(4), .FLUSH_CYC(0), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .req(req_c), .ch_bit(bit_c), .ch_ack(ack_c),
    .grant(gnt_c), .enc_en(en_c), .enc_bit(eb_c), .busy(busy_c), .burst_done(bd_c));

  // Each channel presents bit k of its pattern after k acks.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      bit_a[c] = pat[0][c][ackc[0][c] % 16];
      bit_b[c] = pat[1][c][ackc[1][c] % 16];
      bit_c[c] = pat[2][c][ackc[2][c] % 16];
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (clr) begin
        ackc[0][c] <= 0;
        ackc[1][c] <= 0;
        ackc[2][c] <= 0;
      end else begin
        if (ack_a[c]) ackc[0][c] <= ackc[0][c] + 1;
        if (ack_b[c]) ackc[1][c] <= ackc[1][c] + 1;
        if (ack_c[c]) ackc[2][c] <= ackc[2][c] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Log layout: [5] burst_done [4] busy [3] enc_en [2] enc_bit [1:0] grant.
  task automatic tick();
    @(posedge clk);
    cyc++;
    lg[0][cyc] = {bd_a, busy_a, en_a, eb_a, gnt_a};
    lg[1][cyc] = {bd_b, busy_b, en_b, eb_b, gnt_b};
    lg[2][cyc] = {bd_c, busy_c, en_c, eb_c, gnt_c};
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    clr   = 1'b1;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    run(2);
    rst = 1'b1;
    clr = 1'b0;
    run(1);
  endtask

  function automatic int cnt_en(input int i, input int s, input int e);
    int n = 0;
    for (int k = s; k <= e; k++) n += int'(lg[i][k][3]);
    return n;
  endfunction

  function automatic logic [3:0] bits4(input int i, input int s);
    return {lg[i][s][2], lg[i][s+1][2], lg[i][s+2][2], lg[i][s+3][2]};
  endfunction

  initial begin
    pat[0][0] = 16'h004D;
    pat[0][1] = 16'h0006;
    pat[1][0] = 16'hA5A5;
    pat[1][1] = 16'h0003;
    pat[2][0] = 16'h00F3;
    pat[2][1] = 16'h0000;
    req_a = '0;
    req_b = '0;
    req_c = '0;

    // reset state, with requests pending
    run(1);
    req_a = 2'b11;
    req_b = 2'b11;
    run(1);
    check("rst_gnt", gnt_a, 2'b00);
    check("rst_ack", ack_a, 2'b00);
    check("rst_outs", {en_a, eb_a, busy_a, bd_a}, 4'b0000);
    check("rst_ack_b", ack_b, 2'b00);

    // single 4-bit burst from channel 0
    do_reset();
    m = cyc;
    req_a = 2'b01;
    run(5);
    req_a = 2'b00;
    run(8);
    check("t1_gnt", lg[0][m+1][1:0], 2'b01);
    check("t1_busy", lg[0][m+1][4], 1'b1);
    check("t1_en_lat", lg[0][m+1][3], 1'b0);
    check("t1_bits", bits4(0, m+2), 4'b1011);
    check("t1_en_cnt", cnt_en(0, m+1, m+13), 4);
    check("t1_low", cnt_en(0, m+6, m+10), 0);
    check("t1_bd_pre", lg[0][m+9][5], 1'b0);
    check("t1_bd", lg[0][m+10][5], 1'b1);
    check("t1_bd_post", lg[0][m+11][5], 1'b0);
    check("t1_gnt_hold", lg[0][m+9][1:0], 2'b01);
    check("t1_gnt_clr", lg[0][m+10][1:0], 2'b00);
    check("t1_busy_clr", lg[0][m+10][4], 1'b0);
    check("t1_acks", ackc[0][0], 4);

    // both channels requesting
    do_reset();
    m = cyc;
    req_a = 2'b11;
    run(30);
    req_a = 2'b00;
    run(12);
    check("t2_gnt1", lg[0][m+1][1:0], 2'b01);
    check("t2_bits1", bits4(0, m+2), 4'b1011);
    check("t2_gap", cnt_en(0, m+6, m+11), 0);
    check("t2_en2", lg[0][m+12][3], 1'b1);
    check("t2_en_cnt", cnt_en(0, m+1, m+42), 12);
    check("t2_gnt3", lg[0][m+21][1:0], 2'b01);
`ifdef HDB3_SCHED_PRIO_EN
    check("t2_gnt2", lg[0][m+11][1:0], 2'b01);
    check("t2_bits2", bits4(0, m+12), 4'b0010);
    check("t2_bits3", bits4(0, m+22), 4'b0000);
    check("t2_ack0", ackc[0][0], 12);
    check("t2_ack1", ackc[0][1], 0);
`else
    check("t2_gnt2", lg[0][m+11][1:0], 2'b10);
    check("t2_bits2", bits4(0, m+12), 4'b0110);
    check("t2_bits3", bits4(0, m+22), 4'b0010);
    check("t2_ack0", ackc[0][0], 8);
    check("t2_ack1", ackc[0][1], 4);
`endif

    // channel 1 drops req after 2 bits of a 16-bit burst
    do_reset();
    m = cyc;
    req_b = 2'b10;
    run(3);
    req_b = 2'b00;
    run(10);
    check("t3_gnt", lg[1][m+1][1:0], 2'b10);
    check("t3_bits", {lg[1][m+2][2], lg[1][m+3][2]}, 2'b11);
    check("t3_en_off", lg[1][m+4][3], 1'b0);
    check("t3_en_cnt", cnt_en(1, m+1, m+13), 2);
    check("t3_bd_pre", lg[1][m+8][5], 1'b0);
    check("t3_bd", lg[1][m+9][5], 1'b1);
    check("t3_gnt_hold", lg[1][m+8][1:0], 2'b10);
    check("t3_gnt_clr", lg[1][m+9][1:0], 2'b00);
    check("t3_acks", ackc[1][1], 2);

    // reset pulled mid-burst
    do_reset();
    m = cyc;
    req_b = 2'b01;
    run(8);
    check("t4_mid_en", lg[1][m+8][3], 1'b1);
    check("t4_mid_acks", ackc[1][0], 7);
    rst = 1'b0;
    #1;
    check("t4_gnt0", gnt_b, 2'b00);
    check("t4_outs0", {en_b, eb_b, busy_b, bd_b}, 4'b0000);
    check("t4_ack0", ack_b, 2'b00);
    req_b = 2'b10;
    run(1);
    rst = 1'b1;
    m = cyc;
    run(2);
    check("t4_gnt_new", lg[1][m+1][1:0], 2'b10);
    check("t4_en_new", lg[1][m+1][3], 1'b0);
    req_b = 2'b00;
    run(20);

    // FLUSH_CYC=0 instance, back-to-back bursts
    do_reset();
    m = cyc;
    req_c = 2'b01;
    run(12);
    req_c = 2'b00;
    run(8);
    check("t5_gnt", lg[2][m+1][1:0], 2'b01);
    check("t5_bits1", bits4(2, m+2), 4'b1100);
    check("t5_bd", lg[2][m+6][5], 1'b1);
    check("t5_low", {lg[2][m+6][3], lg[2][m+7][3]}, 2'b00);
    check("t5_gnt_clr", lg[2][m+6][1:0], 2'b00);
    check("t5_gnt2", lg[2][m+7][1:0], 2'b01);
    check("t5_bits2", bits4(2, m+8), 4'b1111);
    check("t5_en_cnt", cnt_en(2, m+1, m+20), 8);

    // channel 1 requests during channel 0 flush
    do_reset();
    m = cyc;
    req_a = 2'b01;
    run(6);
    req_a = 2'b10;
    run(5);
    check("t6_gnt", gnt_a, 2'b10);
    check("t6_gnt_idle", lg[0][m+10][1:0], 2'b00);
    check("t6_no_early", ackc[0][1], 0);
    check("t6_en_idle", en_a, 1'b0);
    run(5);
    req_a = 2'b00;
    run(10);
    check("t6_bits", bits4(0, m+12), 4'b0110);
    check("t6_ack1", ackc[0][1], 4);
    check("t6_ack0", ackc[0][0], 4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
